// File: rtl/button_debounce_pulse_pkg.sv
// Shared types and defaults for the start-button conditioning stage.
package button_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int unsigned CNT_W_DEFAULT           = 20;

endpackage

// File: rtl/button_debounce_pulse_sync_2ff.sv
// Width-W two-flop synchroniser for asynchronous board inputs, cleared to 0 on reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_debounce_pulse.sv
// Start-button debouncer: one registered pulse per accepted press, debounced level, press counter.
// Optional macro SW_SNAPSHOT_EN latches the switch word on each accepted press.
//
// state        | meaning
// IDLE         | button released and stable
// PRESS_WAIT   | button seen high, counting stable-high cycles
// HELD         | press accepted, button still down
// RELEASE_WAIT | button seen low, counting stable-low cycles
module button_debounce_pulse
  import button_debounce_pulse_pkg::*;
#(
  parameter int          CNT_W           = CNT_W_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic [7:0] sw_raw,
  output logic       btn_pulse,
  output logic       btn_level,
  output logic [7:0] sw_out,
  output logic [7:0] press_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic       btn_sync;
  logic [7:0] sw_sync;

  sync_2ff #(.W(1)) u_sync_btn (
    .clk (clk),
    .rst (rst),
    .d_i (btn_raw),
    .q_o (btn_sync)
  );

  sync_2ff #(.W(8)) u_sync_sw (
    .clk (clk),
    .rst (rst),
    .d_i (sw_raw),
    .q_o (sw_sync)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q;
  logic             level_q, level_d;
  logic [7:0]       press_cnt_q, press_cnt_d;
  logic             accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // Bounce back to HELD is the same press: no pulse, no count.
        if (btn_sync) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    level_d     = (state_d == HELD) || (state_d == RELEASE_WAIT);
    press_cnt_d = accept ? press_cnt_q + 8'd1 : press_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pulse_q     <= 1'b0;
      level_q     <= 1'b0;
      press_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_q     <= accept;
      level_q     <= level_d;
      press_cnt_q <= press_cnt_d;
    end
  end

`ifdef SW_SNAPSHOT_EN
  // Hold the word steady while the detector scans it after the start pulse.
  logic [7:0] sw_snap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_snap_q <= 8'h00;
    end else if (accept) begin
      sw_snap_q <= sw_sync;
    end
  end

  assign sw_out = sw_snap_q;
`else
  assign sw_out = sw_sync;
`endif

  assign btn_pulse = pulse_q;
  assign btn_level = level_q;
  assign press_cnt = press_cnt_q;

endmodule
